// File: rtl/muldiv_pkg.sv
// Shared state encoding and default sizing for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    localparam int W_DEFAULT       = 32;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter width for a watchdog that must count TIMEOUT cycles (0 .. TIMEOUT-1).
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regfile.sv
// Architectural HI/LO registers with MTHI/MTLO write select, result commit and done-cycle read bypass.
module hilo_regfile
    import muldiv_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [W-1:0] wr_data,
    input  logic         res_en,
    input  logic [W-1:0] res_hi,
    input  logic [W-1:0] res_lo,
    input  logic         byp_en,
    input  logic         rd_sel,
    output logic [W-1:0] rd_data
);

    logic [W-1:0] hi_q;
    logic [W-1:0] hi_d;
    logic [W-1:0] lo_q;
    logic [W-1:0] lo_d;

    // A unit result and an MTHI/MTLO never coincide upstream; the result takes priority regardless.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (res_en) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (wr_en) begin
            if (wr_sel) begin
                lo_d = wr_data;
            end else begin
                hi_d = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // On the done cycle the result is not yet in hi_q/lo_q, so forward it straight from the unit.
    always_comb begin
        rd_data = rd_sel ? lo_q : hi_q;
        if (byp_en) begin
            rd_data = rd_sel ? res_lo : res_hi;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: issues operands to the iterative unit, watches for completion
// or watchdog expiry, commits HI/LO and raises stall requests while a result is outstanding.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_e,
    input  logic         mul0_div1_e,
    input  logic         flush_e,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         hilo_rd_e,
    input  logic         hilo_wr_e,
    input  logic         hi0_lo1_e,
    input  logic [W-1:0] wr_data,
    output logic         unit_start,
    output logic         unit_div,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    input  logic         unit_done,
    input  logic [W-1:0] unit_hi,
    input  logic [W-1:0] unit_lo,
    output logic [W-1:0] hilo_rd_data,
    output logic         stall_e,
    output logic         busy,
    output logic         div_zero,
    output logic         timeout_err
);

    localparam int               CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             unit_start_q;
    logic             unit_start_d;
    logic             unit_div_q;
    logic             unit_div_d;
    logic [W-1:0]     unit_a_q;
    logic [W-1:0]     unit_a_d;
    logic [W-1:0]     unit_b_q;
    logic [W-1:0]     unit_b_d;
    logic             div_zero_q;
    logic             div_zero_d;
    logic             timeout_err_q;
    logic             timeout_err_d;

    logic in_idle;
    logic in_run;
    logic accept;
    logic div_by_zero;
    logic launch;
    logic hilo_wr_ok;
    logic result_wr;
    logic abort;

    // Acceptance only happens in IDLE; once RUN is entered the op is committed and flush_e is ignored.
    always_comb begin
        in_idle     = (state_q == ST_IDLE);
        in_run      = (state_q == ST_RUN);
        accept      = in_idle & start_e & ~flush_e;
        div_by_zero = accept & mul0_div1_e & (op_b == '0);
        launch      = accept & ~div_by_zero;
        hilo_wr_ok  = in_idle & hilo_wr_e & ~flush_e & ~start_e;
        result_wr   = in_run & unit_done;
        abort       = in_run & ~unit_done & (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        unit_start_d  = 1'b0;
        unit_div_d    = unit_div_q;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        div_zero_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                div_zero_d = div_by_zero;
                if (launch) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    unit_start_d = 1'b1;
                    unit_div_d   = mul0_div1_e;
                    unit_a_d     = op_a;
                    unit_b_d     = op_b;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (result_wr) begin
                    state_d = ST_IDLE;
                end else if (abort) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            unit_start_q  <= 1'b0;
            unit_div_q    <= 1'b0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            div_zero_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            unit_start_q  <= unit_start_d;
            unit_div_q    <= unit_div_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            div_zero_q    <= div_zero_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // A read on the done cycle is served by the bypass, so it alone never stalls.
    always_comb begin
        stall_e = in_run & (start_e | hilo_wr_e | (hilo_rd_e & ~unit_done));
    end

    assign busy        = in_run;
    assign unit_start  = unit_start_q;
    assign unit_div    = unit_div_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign div_zero    = div_zero_q;
    assign timeout_err = timeout_err_q;

    hilo_regfile #(
        .W (W)
    ) u_hilo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hilo_wr_ok),
        .wr_sel  (hi0_lo1_e),
        .wr_data (wr_data),
        .res_en  (result_wr),
        .res_hi  (unit_hi),
        .res_lo  (unit_lo),
        .byp_en  (result_wr),
        .rd_sel  (hi0_lo1_e),
        .rd_data (hilo_rd_data)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the stimulus plays the EX stage and the iterative unit.
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_e;
    logic         mul0_div1_e;
    logic         flush_e;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         hilo_rd_e;
    logic         hilo_wr_e;
    logic         hi0_lo1_e;
    logic [W-1:0] wr_data;
    logic         unit_start;
    logic         unit_div;
    logic [W-1:0] unit_a;
    logic [W-1:0] unit_b;
    logic         unit_done;
    logic [W-1:0] unit_hi;
    logic [W-1:0] unit_lo;
    logic [W-1:0] hilo_rd_data;
    logic         stall_e;
    logic         busy;
    logic         div_zero;
    logic         timeout_err;

    muldiv_ctrl #(.W(W), .TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_e      (start_e),
        .mul0_div1_e  (mul0_div1_e),
        .flush_e      (flush_e),
        .op_a         (op_a),
        .op_b         (op_b),
        .hilo_rd_e    (hilo_rd_e),
        .hilo_wr_e    (hilo_wr_e),
        .hi0_lo1_e    (hi0_lo1_e),
        .wr_data      (wr_data),
        .unit_start   (unit_start),
        .unit_div     (unit_div),
        .unit_a       (unit_a),
        .unit_b       (unit_b),
        .unit_done    (unit_done),
        .unit_hi      (unit_hi),
        .unit_lo      (unit_lo),
        .hilo_rd_data (hilo_rd_data),
        .stall_e      (stall_e),
        .busy         (busy),
        .div_zero     (div_zero),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic         div;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } start_t;

    typedef struct {
        logic [W-1:0] val;
        string        tag;
    } rd_t;

    typedef struct {
        int    cyc;
        logic  stall;
        logic  busy;
        logic  terr;
        logic  chk_unit;
        string tag;
    } probe_t;

    start_t start_q[$];
    int     dz_q[$];
    rd_t    rd_q[$];
    probe_t probe_q[$];

    int total = 0;
    int bad   = 0;
    bit tb_end = 1'b0;
    bit end_done = 1'b0;

    start_t m_s;
    rd_t    m_r;
    probe_t m_p;
    int     m_dz;

    // Monitor: every comparison lives here, sampled on the falling edge.
    always @(negedge clk) begin
        if (unit_start) begin
            total++;
            if (start_q.size() == 0) begin
                bad++;
                $display("FAIL unit_start: unexpected pulse cyc=%0d a=%h b=%h", cyc, unit_a, unit_b);
            end else begin
                m_s = start_q.pop_front();
                if (m_s.cyc != cyc || unit_div !== m_s.div || unit_a !== m_s.a || unit_b !== m_s.b) begin
                    bad++;
                    $display("FAIL unit_start: got cyc=%0d div=%b a=%h b=%h, want cyc=%0d div=%b a=%h b=%h",
                             cyc, unit_div, unit_a, unit_b, m_s.cyc, m_s.div, m_s.a, m_s.b);
                end
            end
        end
        if (start_q.size() > 0 && start_q[0].cyc < cyc) begin
            m_s = start_q.pop_front();
            total++;
            bad++;
            $display("FAIL unit_start: missing pulse, got none want cyc=%0d", m_s.cyc);
        end
        if (div_zero) begin
            total++;
            if (dz_q.size() == 0) begin
                bad++;
                $display("FAIL div_zero: unexpected pulse cyc=%0d", cyc);
            end else begin
                m_dz = dz_q.pop_front();
                if (m_dz != cyc) begin
                    bad++;
                    $display("FAIL div_zero: got cyc=%0d want cyc=%0d", cyc, m_dz);
                end
            end
        end
        if (dz_q.size() > 0 && dz_q[0] < cyc) begin
            m_dz = dz_q.pop_front();
            total++;
            bad++;
            $display("FAIL div_zero: missing pulse, got none want cyc=%0d", m_dz);
        end
        if (hilo_rd_e && !stall_e) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL hilo_rd: unexpected read completion cyc=%0d data=%h", cyc, hilo_rd_data);
            end else begin
                m_r = rd_q.pop_front();
                if (hilo_rd_data !== m_r.val) begin
                    bad++;
                    $display("FAIL hilo_rd %s: got %h want %h", m_r.tag, hilo_rd_data, m_r.val);
                end
            end
        end
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            m_p = probe_q.pop_front();
            total++;
            if (m_p.cyc != cyc) begin
                bad++;
                $display("FAIL probe %s: skipped, got cyc=%0d want cyc=%0d", m_p.tag, cyc, m_p.cyc);
            end else if (stall_e !== m_p.stall || busy !== m_p.busy || timeout_err !== m_p.terr) begin
                bad++;
                $display("FAIL probe %s: got stall=%b busy=%b terr=%b want stall=%b busy=%b terr=%b",
                         m_p.tag, stall_e, busy, timeout_err, m_p.stall, m_p.busy, m_p.terr);
            end else if (m_p.chk_unit && (unit_start !== 1'b0 || div_zero !== 1'b0 || unit_div !== 1'b0 ||
                                          unit_a !== '0 || unit_b !== '0)) begin
                bad++;
                $display("FAIL probe %s: got start=%b dz=%b div=%b a=%h b=%h want all zero",
                         m_p.tag, unit_start, div_zero, unit_div, unit_a, unit_b);
            end
        end
        if (tb_end && !end_done) begin
            end_done = 1'b1;
            total++;
            if (start_q.size() != 0 || dz_q.size() != 0 || rd_q.size() != 0 || probe_q.size() != 0) begin
                bad++;
                $display("FAIL leftovers: got start=%0d dz=%0d rd=%0d probe=%0d want all 0",
                         start_q.size(), dz_q.size(), rd_q.size(), probe_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_start(input int at, input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
        start_t s;
        s.cyc = at;
        s.div = div;
        s.a   = a;
        s.b   = b;
        start_q.push_back(s);
    endtask

    task automatic push_rd(input logic [W-1:0] val, input string tag);
        rd_t r;
        r.val = val;
        r.tag = tag;
        rd_q.push_back(r);
    endtask

    task automatic push_probe(input logic s, input logic b, input logic t, input logic cu, input string tag);
        probe_t p;
        p.cyc      = cyc;
        p.stall    = s;
        p.busy     = b;
        p.terr     = t;
        p.chk_unit = cu;
        p.tag      = tag;
        probe_q.push_back(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start_e = 1'b0; mul0_div1_e = 1'b0; flush_e = 1'b0;
        op_a = '0; op_b = '0;
        hilo_rd_e = 1'b0; hilo_wr_e = 1'b0; hi0_lo1_e = 1'b0; wr_data = '0;
        unit_done = 1'b0; unit_hi = '0; unit_lo = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset state
        push_probe(0, 0, 0, 1, "reset");
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b0; push_rd(32'h0, "rst_hi"); tick();
        hi0_lo1_e = 1'b1; push_rd(32'h0, "rst_lo"); tick();
        hilo_rd_e = 1'b0;

        // MULT 7*6, MFLO stalls during RUN and is bypassed on the done cycle
        start_e = 1'b1; mul0_div1_e = 1'b0; op_a = 32'd7; op_b = 32'd6;
        push_start(cyc + 1, 1'b0, 32'd7, 32'd6); tick();
        start_e = 1'b0;
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b1;
        push_probe(1, 1, 0, 0, "mflo_stall0"); tick();
        push_probe(1, 1, 0, 0, "mflo_stall1"); tick();
        push_probe(1, 1, 0, 0, "mflo_stall2"); tick();
        unit_done = 1'b1; unit_hi = 32'd0; unit_lo = 32'd42;
        push_rd(32'd42, "lo_bypass"); push_probe(0, 1, 0, 0, "done_nostall"); tick();
        unit_done = 1'b0;
        push_rd(32'd42, "lo_commit"); push_probe(0, 0, 0, 0, "idle_after_mult"); tick();
        hi0_lo1_e = 1'b0; push_rd(32'd0, "hi_commit"); tick();
        hilo_rd_e = 1'b0;

        // Flushed MULT must not start; flushed MTHI must not write
        start_e = 1'b1; flush_e = 1'b1; op_a = 32'd9; op_b = 32'd9; tick();
        start_e = 1'b0; push_probe(0, 0, 0, 0, "flushed_start"); tick();
        hilo_wr_e = 1'b1; hi0_lo1_e = 1'b0; wr_data = 32'hDEADBEEF; tick();
        hilo_wr_e = 1'b0; flush_e = 1'b0;
        hilo_rd_e = 1'b1; push_rd(32'h0, "mthi_flushed"); tick();
        hilo_rd_e = 1'b0; hilo_wr_e = 1'b1; tick();
        hilo_wr_e = 1'b0; hilo_rd_e = 1'b1; push_rd(32'hDEADBEEF, "mthi"); tick();
        hilo_rd_e = 1'b0; hilo_wr_e = 1'b1; hi0_lo1_e = 1'b1; wr_data = 32'h0000_1111; tick();
        hilo_wr_e = 1'b0; hilo_rd_e = 1'b1; push_rd(32'h0000_1111, "mtlo"); tick();
        hi0_lo1_e = 1'b0; push_rd(32'hDEADBEEF, "hi_kept"); tick();
        hilo_rd_e = 1'b0;

        // DIV by zero: one-cycle div_zero, no start, HI/LO untouched
        start_e = 1'b1; mul0_div1_e = 1'b1; op_a = 32'd10; op_b = 32'd0;
        dz_q.push_back(cyc + 1); tick();
        start_e = 1'b0; mul0_div1_e = 1'b0;
        push_probe(0, 0, 0, 0, "div0_idle");
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b0; push_rd(32'hDEADBEEF, "div0_hi"); tick();
        hi0_lo1_e = 1'b1; push_rd(32'h0000_1111, "div0_lo"); tick();
        hilo_rd_e = 1'b0;

        // DIV 100/7 then a second MULT held in EX while busy, plus a losing MTLO
        start_e = 1'b1; mul0_div1_e = 1'b1; op_a = 32'd100; op_b = 32'd7;
        push_start(cyc + 1, 1'b1, 32'd100, 32'd7); tick();
        mul0_div1_e = 1'b0; op_a = 32'h0001_0000; op_b = 32'h0003_0000;
        push_probe(1, 1, 0, 0, "busy_stall0"); tick();
        push_probe(1, 1, 0, 0, "busy_stall1"); tick();
        unit_done = 1'b1; unit_hi = 32'd2; unit_lo = 32'd14;
        push_probe(1, 1, 0, 0, "done_stall"); tick();
        unit_done = 1'b0; hilo_wr_e = 1'b1; hi0_lo1_e = 1'b1; wr_data = 32'h0000_0BAD;
        push_start(cyc + 1, 1'b0, 32'h0001_0000, 32'h0003_0000);
        push_probe(0, 0, 0, 0, "second_accept"); tick();
        start_e = 1'b0; hilo_wr_e = 1'b0;
        push_probe(0, 1, 0, 0, "second_run"); tick();
        unit_done = 1'b1; unit_hi = 32'd3; unit_lo = 32'd0; tick();
        unit_done = 1'b0;
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b1; push_rd(32'd0, "lo_second"); tick();
        hi0_lo1_e = 1'b0; push_rd(32'd3, "hi_second"); tick();
        hilo_rd_e = 1'b0;

        // Watchdog: unit never answers, abort after 64 RUN cycles
        start_e = 1'b1; op_a = 32'd1; op_b = 32'd1;
        push_start(cyc + 1, 1'b0, 32'd1, 32'd1); tick();
        start_e = 1'b0;
        push_probe(0, 1, 0, 0, "to_run");
        repeat (63) tick();
        push_probe(0, 1, 0, 0, "to_last"); tick();
        push_probe(0, 0, 1, 0, "to_abort");
        unit_done = 1'b1; unit_hi = 32'h5555; unit_lo = 32'h5555; tick();
        unit_done = 1'b0;
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b1; push_rd(32'd0, "lo_after_to"); tick();
        hi0_lo1_e = 1'b0; push_rd(32'd3, "hi_after_to"); push_probe(0, 0, 1, 0, "terr_sticky"); tick();
        hilo_rd_e = 1'b0;

        // Reset in the middle of RUN
        start_e = 1'b1; op_a = 32'd5; op_b = 32'd9;
        push_start(cyc + 1, 1'b0, 32'd5, 32'd9); tick();
        start_e = 1'b0;
        push_probe(0, 1, 1, 0, "pre_reset_run"); tick();
        rst = 1'b0; #1;
        push_probe(0, 0, 0, 1, "reset_midrun"); tick();
        tick();
        rst = 1'b1;
        hilo_rd_e = 1'b1; hi0_lo1_e = 1'b0; push_rd(32'd0, "hi_after_rst"); tick();
        hi0_lo1_e = 1'b1; push_rd(32'd0, "lo_after_rst"); tick();
        hilo_rd_e = 1'b0;

        tb_end = 1'b1;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
